mux_n_to_1_reg: RTL and testbench



---
 rtl/mux_n_to_1_reg.sv | 78 +++++++
 tb/tb_mux_n_to_1_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_reg.sv
// Registered NUM_IN:1 valid/ready channel selector with a select lock for
// multi-beat transfers and a registered out-of-range select flag.
module mux_n_to_1_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    lock,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  // One extra bit so NUM_IN == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic             lock_active;
  logic [SEL_W-1:0] locked_sel;
  logic [SEL_W-1:0] eff_sel;
  logic             in_range;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // Effective select, range check and output-slot availability.
  always_comb begin
    eff_sel  = lock_active ? locked_sel : sel;
    in_range = ({1'b0, eff_sel} < NUM_IN_W);
    can_load = !out_valid || out_ready;
  end

  // Per-channel ready, selected data and transfer detect.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    xfer     = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!reset && can_load && in_range && (eff_sel == SEL_W'(i))) begin
        in_ready[i] = 1'b1;
        sel_data    = in_data[i*WIDTH +: WIDTH];
        xfer        = in_valid[i];
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Lock state, error flag and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active <= 1'b0;
      locked_sel  <= '0;
      sel_err     <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else begin
      lock_active <= lock;
      if (lock && !lock_active) begin
        locked_sel <= sel;
      end
      sel_err <= !in_range;
      if (xfer) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Scoreboard bench for mux_n_to_1_reg: default 4x16 instance, a 5-input
// 3-bit-select instance and a randomised 8x32 instance.
module tb_mux_n_to_1_reg;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [63:0]  a_in_data;
  logic [3:0]   a_in_valid, a_in_ready;
  logic [1:0]   a_sel;
  logic         a_lock, a_out_valid, a_out_ready, a_sel_err;
  logic [15:0]  a_out_data;

  logic [79:0]  b_in_data;
  logic [4:0]   b_in_valid, b_in_ready;
  logic [2:0]   b_sel;
  logic         b_lock, b_out_valid, b_out_ready, b_sel_err;
  logic [15:0]  b_out_data;

  logic [255:0] c_in_data;
  logic [7:0]   c_in_valid, c_in_ready;
  logic [2:0]   c_sel;
  logic         c_lock, c_out_valid, c_out_ready, c_sel_err;
  logic [31:0]  c_out_data;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [31:0] qc[$];

  mux_n_to_1_reg #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .lock(a_lock), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .sel_err(a_sel_err));

  mux_n_to_1_reg #(.WIDTH(16), .NUM_IN(5), .SEL_W(3)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .lock(b_lock), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err));

  mux_n_to_1_reg #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .lock(c_lock), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .sel_err(c_sel_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: every word taken downstream must match the queue head.
  always @(negedge clk) begin
    if (!reset && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_extra_word: got 0x%0h, expected no word", a_out_data);
      end else begin
        chk("a_out_data", 64'(a_out_data), 64'(qa.pop_front()));
      end
    end
    if (!reset && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_extra_word: got 0x%0h, expected no word", b_out_data);
      end else begin
        chk("b_out_data", 64'(b_out_data), 64'(qb.pop_front()));
      end
    end
    if (!reset && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        checks++; failures++;
        $display("FAIL c_extra_word: got 0x%0h, expected no word", c_out_data);
      end else begin
        chk("c_out_data", 64'(c_out_data), 64'(qc.pop_front()));
      end
    end
  end

  initial begin
    logic [15:0] basic_exp [4];
    logic [3:0]  exp_a;
    logic [7:0]  exp_c;
    logic        mov;
    logic        can;
    basic_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    checks = 0;
    failures = 0;
    reset = 1'b1;
    a_in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    a_in_valid = 4'hF; a_sel = 2'd0; a_lock = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 5'd0; b_sel = 3'd0; b_lock = 1'b0; b_out_ready = 1'b0;
    c_in_data = '0; c_in_valid = 8'd0; c_sel = 3'd0; c_lock = 1'b0; c_out_ready = 1'b0;

    // Reset cycle: no readiness, then everything cleared.
    @(negedge clk);
    chk("reset_in_ready", 64'(a_in_ready), 64'(4'b0000));
    next_cycle();
    chk("reset_out_valid", 64'(a_out_valid), 64'(1'b0));
    chk("reset_out_data", 64'(a_out_data), 64'(16'h0000));
    chk("reset_sel_err", 64'(a_sel_err), 64'(1'b0));
    chk("reset_c_out_valid", 64'(c_out_valid), 64'(1'b0));
    reset = 1'b0;

    // Basic select sweep at full throughput.
    for (int s = 0; s < 4; s++) begin
      a_sel = s[1:0];
      exp_a = 4'b0001 << s;
      qa.push_back(basic_exp[s]);
      @(negedge clk);
      chk("basic_in_ready", 64'(a_in_ready), 64'(exp_a));
      if (s > 0) chk("basic_out_valid", 64'(a_out_valid), 64'(1'b1));
      next_cycle();
    end

    // Back-pressure: 0xABCD must survive three stalled cycles.
    a_sel = 2'd1; a_in_data[16 +: 16] = 16'hABCD; qa.push_back(16'hABCD);
    @(negedge clk);
    chk("bp_load_ready", 64'(a_in_ready), 64'(4'b0010));
    next_cycle();
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_data[16 +: 16] = 16'h1001 + 16'(k);
      @(negedge clk);
      chk("bp_stall_ready", 64'(a_in_ready), 64'(4'b0000));
      chk("bp_stall_data", 64'(a_out_data), 64'(16'hABCD));
      chk("bp_stall_valid", 64'(a_out_valid), 64'(1'b1));
      next_cycle();
    end
    a_out_ready = 1'b1; a_in_data[16 +: 16] = 16'hBEEF; qa.push_back(16'hBEEF);
    @(negedge clk);
    chk("bp_release_ready", 64'(a_in_ready), 64'(4'b0010));
    next_cycle();

    // Lock: ch2 held for the lock window plus one cycle, then ch0 goes live.
    a_in_data[0 +: 16] = 16'hD000;
    for (int k = 0; k < 6; k++) begin
      a_lock = (k < 4);
      a_sel = (k == 0) ? 2'd2 : 2'd0;
      a_in_data[32 +: 16] = 16'hC001 + 16'(k);
      exp_a = (k < 5) ? 4'b0100 : 4'b0001;
      qa.push_back((k < 5) ? (16'hC001 + 16'(k)) : 16'hD000);
      @(negedge clk);
      chk("lock_in_ready", 64'(a_in_ready), 64'(exp_a));
      next_cycle();
    end

    // Reset mid-operation with a held word and an active lock on ch3.
    a_sel = 2'd3; a_lock = 1'b1; a_in_data[48 +: 16] = 16'h5A5A;
    @(negedge clk);
    chk("rst_pre_ready", 64'(a_in_ready), 64'(4'b1000));
    next_cycle();
    a_out_ready = 1'b0; reset = 1'b1; a_sel = 2'd0;
    @(negedge clk);
    chk("rst_pre_data", 64'(a_out_data), 64'(16'h5A5A));
    chk("rst_pre_valid", 64'(a_out_valid), 64'(1'b1));
    chk("rst_cycle_ready", 64'(a_in_ready), 64'(4'b0000));
    next_cycle();
    reset = 1'b0; a_lock = 1'b0; a_sel = 2'd1; a_out_ready = 1'b1;
    a_in_data[16 +: 16] = 16'h7777; qa.push_back(16'h7777);
    @(negedge clk);
    chk("rst_post_valid", 64'(a_out_valid), 64'(1'b0));
    chk("rst_post_data", 64'(a_out_data), 64'(16'h0000));
    chk("rst_post_sel_err", 64'(a_sel_err), 64'(1'b0));
    chk("rst_post_ready", 64'(a_in_ready), 64'(4'b0010));
    next_cycle();
    a_in_valid = 4'h0;
    next_cycle();
    @(negedge clk);
    chk("rst_drain_valid", 64'(a_out_valid), 64'(1'b0));
    next_cycle();

    // Out-of-range select on the 5-input instance.
    for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = 16'hB000 + 16'(i);
    b_in_valid = 5'h1F; b_sel = 3'd2; b_out_ready = 1'b1; qb.push_back(16'hB002);
    @(negedge clk);
    chk("oor_load_ready", 64'(b_in_ready), 64'(5'b00100));
    next_cycle();
    b_sel = 3'd6; b_out_ready = 1'b0;
    @(negedge clk);
    chk("oor_ready", 64'(b_in_ready), 64'(5'b00000));
    chk("oor_pending_valid", 64'(b_out_valid), 64'(1'b1));
    next_cycle();
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("oor_sel_err", 64'(b_sel_err), 64'(1'b1));
    chk("oor_ready_2", 64'(b_in_ready), 64'(5'b00000));
    chk("oor_taken_valid", 64'(b_out_valid), 64'(1'b1));
    next_cycle();
    b_sel = 3'd4; qb.push_back(16'hB004);
    @(negedge clk);
    chk("oor_fell_valid", 64'(b_out_valid), 64'(1'b0));
    chk("oor_sel_err_held", 64'(b_sel_err), 64'(1'b1));
    chk("oor_ch4_ready", 64'(b_in_ready), 64'(5'b10000));
    next_cycle();
    b_in_valid = 5'h00;
    @(negedge clk);
    chk("oor_ch4_valid", 64'(b_out_valid), 64'(1'b1));
    chk("oor_sel_err_clear", 64'(b_sel_err), 64'(1'b0));
    next_cycle();

    // Randomised 8x32 traffic against a small reference of the output slot.
    mov = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      for (int i = 0; i < 8; i++) c_in_data[i*32 +: 32] = $urandom;
      c_in_valid  = 8'($urandom);
      c_sel       = 3'($urandom_range(0, 7));
      c_out_ready = ($urandom_range(0, 3) != 0);
      can   = !mov || c_out_ready;
      exp_c = can ? (8'b0000_0001 << c_sel) : 8'b0000_0000;
      if (can && c_in_valid[c_sel]) qc.push_back(c_in_data[int'(c_sel)*32 +: 32]);
      @(negedge clk);
      chk("rand_in_ready", 64'(c_in_ready), 64'(exp_c));
      chk("rand_out_valid", 64'(c_out_valid), 64'(mov));
      if (can && c_in_valid[c_sel]) mov = 1'b1;
      else if (c_out_ready) mov = 1'b0;
      next_cycle();
    end

    c_in_valid = 8'h00; c_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) next_cycle();
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    chk("qc_empty", 64'(qc.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
